// File: rtl/elixir_bank_pkg.sv
// rtl/elixir_bank_pkg.sv - shared game constants and bank state encoding
package elixir_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } bank_state_t;

  localparam int ELIXIR_THIRDS = 3;
  localparam int MAX_ELIXIR    = 10;
  localparam int START_ELIXIR  = 5;

endpackage

// File: rtl/elixir_bank_regen_timer.sv
// rtl/elixir_bank_regen_timer.sv - frame-tick edge detect and regen period counter
module elixir_bank_regen_timer #(
  parameter int REGEN_TICKS = 28
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  input  logic run,
  input  logic restart,
  input  logic double_rate,
  output logic grant
);

  localparam int CW = $clog2(REGEN_TICKS + 1);

  logic          frame_q;
  logic          tick;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] period;

  assign tick      = frame_clk & ~frame_q;
  assign period    = double_rate ? CW'(REGEN_TICKS / 2) : CW'(REGEN_TICKS);
  assign count_inc = count + 1'b1;
  // >= rather than == so a period shrink with a large count wraps on the next tick
  assign grant     = run & tick & (count_inc >= period);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_q <= 1'b0;
      count   <= '0;
    end else begin
      frame_q <= frame_clk;
      if (restart) begin
        count <= '0;
      end else if (run && tick) begin
        count <= grant ? '0 : count_inc;
      end
    end
  end

endmodule

// File: rtl/elixir_bank.sv
// rtl/elixir_bank.sv - per-player elixir accumulator with regen and deploy deduction
module elixir_bank
  import elixir_bank_pkg::*;
#(
  parameter int NSLOT        = 4,
  parameter int MAX_ELIXIR   = elixir_bank_pkg::MAX_ELIXIR,
  parameter int START_ELIXIR = elixir_bank_pkg::START_ELIXIR,
  parameter int REGEN_TICKS  = 28
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               double_rate,
  input  logic [NSLOT*5-1:0] elixirin,
  output logic [4:0]         eli,
  output logic [5:0]         fine,
  output logic               full,
  output logic               overdraw
);

  localparam logic [5:0] CAP   = 6'(ELIXIR_THIRDS * MAX_ELIXIR);
  localparam logic [5:0] START = 6'(ELIXIR_THIRDS * START_ELIXIR);

  bank_state_t state, state_nx;
  logic        grant;
  logic [7:0]  total;
  logic        over;
  logic [5:0]  base;
  logic [6:0]  sum;
  logic [5:0]  fine_nx;
  logic        overdraw_nx;

  elixir_bank_regen_timer #(
    .REGEN_TICKS(REGEN_TICKS)
  ) u_regen (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .run        (state == RUN),
    .restart    (game_start),
    .double_rate(double_rate),
    .grant      (grant)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      fine     <= '0;
      overdraw <= 1'b0;
    end else begin
      state    <= state_nx;
      fine     <= fine_nx;
      overdraw <= overdraw_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (game_start) state_nx = RUN;
      RUN:     if (!game_start && game_over) state_nx = HALT;
      HALT:    if (game_start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Costs from several slots in the same cycle all count toward one deduction
  always_comb begin
    total = '0;
    for (int i = 0; i < NSLOT; i++) begin
      total = total + 8'(elixirin[5*i +: 5]);
    end
  end

  always_comb begin
    over        = total > {2'b00, fine};
    base        = over ? 6'd0 : fine - total[5:0];
    sum         = {1'b0, base} + {6'd0, grant};
    fine_nx     = fine;
    overdraw_nx = 1'b0;
    if (game_start) begin
      fine_nx = START;
    end else if (state == RUN) begin
      fine_nx     = (sum > {1'b0, CAP}) ? CAP : sum[5:0];
      overdraw_nx = over;
    end
  end

  assign eli  = 5'(fine / 6'(ELIXIR_THIRDS));
  assign full = (fine == CAP);

endmodule
